// File: rtl/div_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Optional duty-cycle qualification is selected by DUTY_CHECK_EN in div_clk_monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_EXP_DIV  = 6;
  localparam int DEF_TOL      = 0;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 12;
  localparam int DEF_CNT_W    = 8;

  // Lower tolerance bound clamped at zero so unsigned compares never wrap.
  function automatic int floor_sub(input int a, input int b);
    if (a > b) begin
      return a - b;
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with history flop; emits synchronized level and
// single-cycle rise/fall pulses for any asynchronous single-bit input.
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~s3_r;
  assign fall  = ~s2_r & s3_r;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period/high time of a divided clock in sys_clk cycles, tracks lock
// and flags errors and stalls. Define DUTY_CHECK_EN to also qualify duty cycle.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int EXP_DIV  = DEF_EXP_DIV,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZRO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PER_LO  = CNT_W'(floor_sub(EXP_DIV, TOL));
  localparam logic [CNT_W-1:0] PER_HI  = CNT_W'(EXP_DIV + TOL);
  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(floor_sub(EXP_DIV / 2, TOL));
  localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'((EXP_DIV / 2) + TOL);
`endif

  logic             level_s;
  logic             rise_s;
  logic             fall_s;
  logic             match_s;
  logic             period_ok_s;
  logic [CNT_W-1:0] mcnt_inc_s;
  logic [CNT_W-1:0] mcnt_nxt_s;
  logic             vld_nxt_s;
  logic             err_nxt_s;
  logic             to_nxt_s;
  state_e           state_nxt_s;

  state_e           state_r;
  logic [CNT_W-1:0] pcnt_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] mcnt_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_time_r;
  logic             period_vld_r;
  logic             locked_r;
  logic             err_r;
  logic             timeout_r;

  sync_edge_det u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_in  (clk_in),
    .level     (level_s),
    .rise      (rise_s),
    .fall      (fall_s)
  );

  // Period/duty qualification of the measurement ending at this rise.
  always_comb begin
    period_ok_s = (pcnt_r >= PER_LO) && (pcnt_r <= PER_HI);
`ifdef DUTY_CHECK_EN
    match_s = period_ok_s && (high_time_r >= DUTY_LO) && (high_time_r <= DUTY_HI);
`else
    match_s = period_ok_s;
`endif
  end

  // Saturating increment for the consecutive-match counter.
  always_comb begin
    if (mcnt_r == CNT_MAX) begin
      mcnt_inc_s = mcnt_r;
    end else begin
      mcnt_inc_s = mcnt_r + CNT_ONE;
    end
  end

  // Lock FSM next state; a rise always takes precedence over the stall check.
  always_comb begin
    state_nxt_s = state_r;
    mcnt_nxt_s  = mcnt_r;
    vld_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    to_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = TRACK;
          mcnt_nxt_s  = CNT_ZRO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TRACK: begin
        if (rise_s) begin
          vld_nxt_s = 1'b1;
          if (match_s) begin
            mcnt_nxt_s = mcnt_inc_s;
            if (mcnt_inc_s >= LOCK_C) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s = TRACK;
            end
          end else begin
            mcnt_nxt_s = CNT_ZRO;
          end
        end else if (pcnt_r == TO_C) begin
          to_nxt_s    = 1'b1;
          mcnt_nxt_s  = CNT_ZRO;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TRACK;
        end
      end
      LOCKED: begin
        if (rise_s) begin
          vld_nxt_s = 1'b1;
          if (match_s) begin
            state_nxt_s = LOCKED;
          end else begin
            err_nxt_s   = 1'b1;
            mcnt_nxt_s  = CNT_ZRO;
            state_nxt_s = TRACK;
          end
        end else if (pcnt_r == TO_C) begin
          to_nxt_s    = 1'b1;
          mcnt_nxt_s  = CNT_ZRO;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        mcnt_nxt_s  = CNT_ZRO;
      end
    endcase
  end

  // FSM state and registered status pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= IDLE;
      mcnt_r       <= CNT_ZRO;
      period_vld_r <= 1'b0;
      locked_r     <= 1'b0;
      err_r        <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mcnt_r       <= mcnt_nxt_s;
      period_vld_r <= vld_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
      err_r        <= err_nxt_s;
      timeout_r    <= to_nxt_s;
    end
  end

  // Period and high-phase counters, both restarting at 1 on every rise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt_r <= CNT_ZRO;
      hcnt_r <= CNT_ZRO;
    end else begin
      if (rise_s) begin
        pcnt_r <= CNT_ONE;
        hcnt_r <= CNT_ONE;
      end else begin
        if (pcnt_r != CNT_MAX) begin
          pcnt_r <= pcnt_r + CNT_ONE;
        end else begin
          pcnt_r <= pcnt_r;
        end
        if (level_s && (hcnt_r != CNT_MAX)) begin
          hcnt_r <= hcnt_r + CNT_ONE;
        end else begin
          hcnt_r <= hcnt_r;
        end
      end
    end
  end

  // Measurement capture; the first rise after IDLE has no valid period yet.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_r    <= CNT_ZRO;
      high_time_r <= CNT_ZRO;
    end else begin
      if (rise_s && (state_r != IDLE)) begin
        period_r <= pcnt_r;
      end else begin
        period_r <= period_r;
      end
      if (fall_s) begin
        high_time_r <= hcnt_r;
      end else begin
        high_time_r <= high_time_r;
      end
    end
  end

  assign period     = period_r;
  assign high_time  = high_time_r;
  assign period_vld = period_vld_r;
  assign locked     = locked_r;
  assign err        = err_r;
  assign timeout    = timeout_r;

endmodule
